// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory port.
// Holds the FSM state encoding, the legal latency range and the width
// of the wait counter. The counter width covers LATENCY_MAX - 2.
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LATENCY_MIN  = 1;
  localparam int LATENCY_MAX  = 15;
  localparam int COUNTER_BITS = 4;

endpackage : data_memory_pkg

// File: rtl/byte_en_ram.sv
// Single-port word RAM with per-byte write enables.
// Ports:
//   clock   - write clock
//   we      - write strobe for the addressed word
//   byte_en - byte lanes to update when we=1
//   index   - word index (shared by read and write)
//   wdata   - write data
//   rdata   - asynchronous read of the addressed word (pre-write content)
// Contents are never reset.
module byte_en_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 10
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [INDEX_BITS-1:0]   index,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << INDEX_BITS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] merged_d;

  assign rdata = mem_q[index];

  // Lanes that are not enabled keep the current word content, so a
  // whole-word write of the merged value updates only selected bytes.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign merged_d[8*gi +: 8] = byte_en[gi] ? wdata[8*gi +: 8] : rdata[8*gi +: 8];
  end

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[index] <= merged_d;
    end
  end

endmodule : byte_en_ram

// File: rtl/data_memory_port.sv
// Data-side memory endpoint with ready/valid handshake.
// Ports:
//   clock, reset       - clock and asynchronous active-low reset
//   read, write        - request strobes (both may be set together)
//   byte_en            - write byte lanes
//   address_in         - byte address; word index = address_in[INDEX_BITS+1:2]
//   data_in            - write data
//   data_out           - response data (word content before the request's write)
//   address_out        - echo of the answered request's address
//   valid              - one-cycle response strobe, LATENCY cycles after accept
//   ready              - request can be accepted this cycle (low while waiting)
//   scan               - trace enable, no effect on the hardware
module data_memory_port
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int INDEX_BITS   = 10,
  parameter int LATENCY      = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDRESS_BITS-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [ADDRESS_BITS-1:0] address_out,
  output logic                    valid,
  output logic                    ready,
  input  logic                    scan
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("data_memory_port: LATENCY must be within 1..15");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("data_memory_port: DATA_WIDTH must be a multiple of 8");
  end

  // Counter load value on accept; cycles spent in WAIT = LATENCY-1.
  localparam logic [COUNTER_BITS-1:0] WAIT_INIT =
    (LATENCY > 1) ? COUNTER_BITS'(LATENCY - 2) : '0;

  state_e                  state_q, state_d;
  logic [COUNTER_BITS-1:0] counter_q, counter_d;
  logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [ADDRESS_BITS-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic [ADDRESS_BITS-1:0] address_out_q, address_out_d;

  logic                    accept;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    unused_scan;

  assign unused_scan = scan;
  assign accept      = ready & (read | write);

  byte_en_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .INDEX_BITS(INDEX_BITS)
  ) u_ram (
    .clock  (clock),
    .we     (accept & write),
    .byte_en(byte_en),
    .index  (address_in[INDEX_BITS+1:2]),
    .wdata  (data_in),
    .rdata  (ram_rdata)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      pend_data_q   <= '0;
      pend_addr_q   <= '0;
      data_out_q    <= '0;
      address_out_q <= '0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      pend_data_q   <= pend_data_d;
      pend_addr_q   <= pend_addr_d;
      data_out_q    <= data_out_d;
      address_out_q <= address_out_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    pend_data_d   = pend_data_q;
    pend_addr_d   = pend_addr_q;
    data_out_d    = data_out_q;
    address_out_d = address_out_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          // ram_rdata is the pre-write word: the write lands on this edge.
          pend_data_d = ram_rdata;
          pend_addr_d = address_in;
          counter_d   = WAIT_INIT;
          state_d     = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (counter_q == '0) begin
          state_d = RESP;
        end else begin
          counter_d = counter_q - COUNTER_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Visible outputs change only when a response is presented, so they
    // keep the previous response through IDLE and WAIT.
    if (state_d == RESP) begin
      if (state_q == WAIT) begin
        data_out_d    = pend_data_q;
        address_out_d = pend_addr_q;
      end else begin
        data_out_d    = ram_rdata;
        address_out_d = address_in;
      end
    end
  end

  // Output logic
  always_comb begin
    ready       = (state_q != WAIT);
    valid       = (state_q == RESP);
    data_out    = data_out_q;
    address_out = address_out_q;
  end

endmodule : data_memory_port

// File: tb/tb_data_memory_port.sv
// Directed bench for data_memory_port. Three instances share clock and
// reset: index 0 has LATENCY=1, index 1 LATENCY=3, index 2 LATENCY=4.
module tb_data_memory_port;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rd  [3];
  logic        wr  [3];
  logic [3:0]  be  [3];
  logic [31:0] ad  [3];
  logic [31:0] di  [3];
  logic [31:0] dout[3];
  logic [31:0] aout[3];
  logic        vld [3];
  logic        rdy [3];
  logic        scn [3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  data_memory_port #(.LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset), .read(rd[0]), .write(wr[0]), .byte_en(be[0]),
    .address_in(ad[0]), .data_in(di[0]), .data_out(dout[0]), .address_out(aout[0]),
    .valid(vld[0]), .ready(rdy[0]), .scan(scn[0]));

  data_memory_port #(.LATENCY(3)) dut_l3 (
    .clock(clock), .reset(reset), .read(rd[1]), .write(wr[1]), .byte_en(be[1]),
    .address_in(ad[1]), .data_in(di[1]), .data_out(dout[1]), .address_out(aout[1]),
    .valid(vld[1]), .ready(rdy[1]), .scan(scn[1]));

  data_memory_port #(.LATENCY(4)) dut_l4 (
    .clock(clock), .reset(reset), .read(rd[2]), .write(wr[2]), .byte_en(be[2]),
    .address_in(ad[2]), .data_in(di[2]), .data_out(dout[2]), .address_out(aout[2]),
    .valid(vld[2]), .ready(rdy[2]), .scan(scn[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    rd[k] = r; wr[k] = w; be[k] = b; ad[k] = a; di[k] = d;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Presents a request at a negedge and waits (bounded) for its valid.
  // Returns the number of cycles from accept to valid; 99 if none came.
  task automatic req_wait(input int k, input logic r, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d, output int cyc);
    drive(k, r, w, b, a, d);
    cyc = 0;
    @(negedge clock);
    idle(k);
    cyc = 1;
    while (!vld[k] && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    if (!vld[k]) cyc = 99;
    $display("txn dut%0d rd=%0b wr=%0b be=%h addr=%h din=%h -> dout=%h aout=%h after %0d cycles",
             k, r, w, b, a, d, dout[k], aout[k], cyc);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 3; k++) begin
      idle(k);
      scn[k] = 1'b0;
    end

    // Reset held for three cycles
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_ready", {31'b0, rdy[0]}, 32'd1);
    check("rst_valid", {31'b0, vld[0]}, 32'd0);
    check("rst_dout",  dout[0], 32'h0);
    check("rst_aout",  aout[0], 32'h0);

    // LATENCY=1 full-word write then read
    req_wait(0, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, cyc);
    check("l1_wr_lat",  cyc, 32'd1);
    check("l1_wr_aout", aout[0], 32'h10);
    req_wait(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, cyc);
    check("l1_rd_lat",  cyc, 32'd1);
    check("l1_rd_data", dout[0], 32'hDEADBEEF);
    @(negedge clock);
    check("l1_valid_drop", {31'b0, vld[0]}, 32'd0);
    check("l1_hold_data",  dout[0], 32'hDEADBEEF);

    // Byte-lane merge
    req_wait(0, 1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, cyc);
    req_wait(0, 1'b0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, cyc);
    check("merge_old", dout[0], 32'h11223344);
    req_wait(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, cyc);
    check("merge_rd", dout[0], 32'h11BB33DD);

    // Read-before-write with read and write together
    req_wait(0, 1'b0, 1'b1, 4'hF, 32'h24, 32'h5, cyc);
    req_wait(0, 1'b1, 1'b1, 4'hF, 32'h24, 32'h9, cyc);
    check("rbw_old", dout[0], 32'h5);
    req_wait(0, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0, cyc);
    check("rbw_new", dout[0], 32'h9);

    // byte_en=0 write is a no-op that is still acknowledged
    req_wait(0, 1'b0, 1'b1, 4'h0, 32'h24, 32'hFFFFFFFF, cyc);
    check("be0_ack", cyc, 32'd1);
    req_wait(0, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0, cyc);
    check("be0_rd", dout[0], 32'h9);

    // Aliasing and misalignment
    req_wait(0, 1'b0, 1'b1, 4'hF, 32'h1003, 32'hCAFEF00D, cyc);
    check("alias_wr_aout", aout[0], 32'h1003);
    req_wait(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, cyc);
    check("alias_rd0",      dout[0], 32'hCAFEF00D);
    check("alias_rd0_aout", aout[0], 32'h0);
    req_wait(0, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0, cyc);
    check("alias_rd1000",      dout[0], 32'hCAFEF00D);
    check("alias_rd1000_aout", aout[0], 32'h1000);

    // LATENCY=3 handshake
    req_wait(1, 1'b0, 1'b1, 4'hF, 32'h44, 32'h0, cyc);
    check("l3_lat", cyc, 32'd3);
    @(negedge clock);
    drive(1, 1'b0, 1'b1, 4'hF, 32'h40, 32'h12345678);
    @(negedge clock);                       // cycle t+1
    check("l3_t1_ready", {31'b0, rdy[1]}, 32'd0);
    check("l3_t1_valid", {31'b0, vld[1]}, 32'd0);
    drive(1, 1'b0, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
    @(negedge clock);                       // cycle t+2
    check("l3_t2_ready", {31'b0, rdy[1]}, 32'd0);
    check("l3_t2_valid", {31'b0, vld[1]}, 32'd0);
    drive(1, 1'b0, 1'b1, 4'hF, 32'h44, 32'h77);
    @(negedge clock);                       // cycle t+3
    check("l3_t3_valid", {31'b0, vld[1]}, 32'd1);
    check("l3_t3_ready", {31'b0, rdy[1]}, 32'd1);
    check("l3_t3_aout",  aout[1], 32'h40);
    drive(1, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    @(negedge clock);                       // cycle t+4
    idle(1);
    check("l3_t4_valid", {31'b0, vld[1]}, 32'd0);
    check("l3_t4_ready", {31'b0, rdy[1]}, 32'd0);
    check("l3_t4_hold",  aout[1], 32'h40);
    @(negedge clock);                       // cycle t+5
    check("l3_t5_valid", {31'b0, vld[1]}, 32'd0);
    @(negedge clock);                       // cycle t+6
    check("l3_t6_valid", {31'b0, vld[1]}, 32'd1);
    check("l3_t6_data",  dout[1], 32'h12345678);
    $display("txn dut1 back-to-back read addr=00000040 -> dout=%h aout=%h", dout[1], aout[1]);
    req_wait(1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0, cyc);
    check("l3_ignored_wr", dout[1], 32'h0);

    // LATENCY=4 and reset during WAIT
    req_wait(2, 1'b0, 1'b1, 4'hF, 32'h8, 32'hAAAA5555, cyc);
    check("l4_lat", cyc, 32'd4);
    @(negedge clock);
    drive(2, 1'b0, 1'b1, 4'hF, 32'hC, 32'h1);
    @(negedge clock);
    idle(2);
    check("l4_wait_ready", {31'b0, rdy[2]}, 32'd0);
    reset = 1'b0;
    #1;
    check("l4_rst_ready", {31'b0, rdy[2]}, 32'd1);
    check("l4_rst_valid", {31'b0, vld[2]}, 32'd0);
    check("l4_rst_aout",  aout[2], 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("l4_no_valid_%0d", i), {31'b0, vld[2]}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_data_memory_port
